// File: rtl/alu_req_scheduler_if.sv
// Bundle of the request, sub-unit and result signals of alu_req_scheduler.
// slave is the scheduler side; master is the client/sub-unit side.
interface alu_req_scheduler_if #(
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned CNT_WIDTH = 8
);
   logic [1:0]            Req_Valid;
   logic [1:0]            Req_Ready;
   logic [2*IN_WIDTH-1:0] Req_A;
   logic [2*IN_WIDTH-1:0] Req_B;
   logic [7:0]            Req_FUN;
   logic [IN_WIDTH-1:0]   Unit_A;
   logic [IN_WIDTH-1:0]   Unit_B;
   logic [1:0]            Unit_FUN;
   logic                  Arith_Enable;
   logic                  Logic_Enable;
   logic                  CMP_Enable;
   logic                  SHIFT_Enable;
   logic [OUT_WIDTH-1:0]  Unit_OUT;
   logic                  Unit_Flag;
   logic [OUT_WIDTH-1:0]  Result;
   logic                  Result_Flag;
   logic                  Result_Tag;
   logic                  Result_Valid;
   logic                  Result_Ready;
   logic                  Busy;
   logic [CNT_WIDTH-1:0]  Op_Count;

   modport slave (
      input  Req_Valid, Req_A, Req_B, Req_FUN, Unit_OUT, Unit_Flag, Result_Ready,
      output Req_Ready, Unit_A, Unit_B, Unit_FUN,
             Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable,
             Result, Result_Flag, Result_Tag, Result_Valid, Busy, Op_Count
   );

   modport master (
      output Req_Valid, Req_A, Req_B, Req_FUN, Unit_OUT, Unit_Flag, Result_Ready,
      input  Req_Ready, Unit_A, Unit_B, Unit_FUN,
             Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable,
             Result, Result_Flag, Result_Tag, Result_Valid, Busy, Op_Count
   );
endinterface

// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for a shared registered ALU: accept,
// issue to one sub-unit, capture its result and hand it back with a tag.
module alu_req_scheduler #(
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned CNT_WIDTH = 8
) (
   input logic                CLK,
   input logic                RST,
   alu_req_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t               state_q, state_d;
   logic                 ptr_q, ptr_d;
   logic                 tag_q, tag_d;
   logic [IN_WIDTH-1:0]  a_q, a_d;
   logic [IN_WIDTH-1:0]  b_q, b_d;
   logic [1:0]           fun_q, fun_d;
   logic [3:0]           en_q, en_d;
   logic [OUT_WIDTH-1:0] result_q, result_d;
   logic                 flag_q, flag_d;
   logic                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic       grant;
   logic [1:0] ready;
   logic       accept;
   logic [3:0] sel_fun;

   // Pointer only arbitrates a tie; a lone requester wins regardless.
   always_comb begin
      grant   = (bus.Req_Valid == 2'b11) ? ptr_q : bus.Req_Valid[1];
      ready   = 2'b00;
      if (RST && (state_q == IDLE) && (|bus.Req_Valid))
         ready = grant ? 2'b10 : 2'b01;
      accept  = |(bus.Req_Valid & ready);
      sel_fun = grant ? bus.Req_FUN[7:4] : bus.Req_FUN[3:0];
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      tag_d    = tag_q;
      a_d      = a_q;
      b_d      = b_q;
      fun_d    = fun_q;
      en_d     = en_q;
      result_d = result_q;
      flag_d   = flag_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = grant ? bus.Req_A[2*IN_WIDTH-1:IN_WIDTH] : bus.Req_A[IN_WIDTH-1:0];
               b_d     = grant ? bus.Req_B[2*IN_WIDTH-1:IN_WIDTH] : bus.Req_B[IN_WIDTH-1:0];
               fun_d   = sel_fun[1:0];
               en_d    = 4'b0001 << sel_fun[3:2];
               tag_d   = grant;
               ptr_d   = ~grant;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = CAPTURE;
         CAPTURE: begin
            result_d = bus.Unit_OUT;
            flag_d   = bus.Unit_Flag;
            valid_d  = 1'b1;
            en_d     = '0;
            state_d  = RESP;
         end
         RESP: begin
            if (valid_q && bus.Result_Ready) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         tag_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         fun_q    <= '0;
         en_q     <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         tag_q    <= tag_d;
         a_q      <= a_d;
         b_q      <= b_d;
         fun_q    <= fun_d;
         en_q     <= en_d;
         result_q <= result_d;
         flag_q   <= flag_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.Req_Ready    = ready;
   assign bus.Unit_A       = a_q;
   assign bus.Unit_B       = b_q;
   assign bus.Unit_FUN     = fun_q;
   assign bus.Arith_Enable = en_q[0];
   assign bus.Logic_Enable = en_q[1];
   assign bus.CMP_Enable   = en_q[2];
   assign bus.SHIFT_Enable = en_q[3];
   assign bus.Result       = result_q;
   assign bus.Result_Flag  = flag_q;
   assign bus.Result_Tag   = tag_q;
   assign bus.Result_Valid = valid_q;
   assign bus.Busy         = (state_q != IDLE);
   assign bus.Op_Count     = cnt_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: vector table, hand sequences for backpressure,
// reset, contention and wrap, and a random run against a transaction model.
module tb_alu_req_scheduler;
   localparam int unsigned IW = 16;
   localparam int unsigned OW = 16;
   localparam int unsigned CW = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   alu_req_scheduler_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

   alu_req_scheduler #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_cnt = 8'd0;

   // Reference ALU: {flag, result} for a 4-bit function code.
   function automatic logic [16:0] alu_f(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] o;
      logic        fl;
      o  = '0;
      fl = 1'b0;
      case (f[3:2])
         2'd0: begin
            case (f[1:0])
               2'd0: o = a + b;
               2'd1: o = a - b;
               2'd2: o = b - a;
               default: o = a;
            endcase
            fl = o[15];
         end
         2'd1: begin
            case (f[1:0])
               2'd0: o = a & b;
               2'd1: o = a | b;
               2'd2: o = a ^ b;
               default: o = ~a;
            endcase
            fl = |o;
         end
         2'd2: begin
            case (f[1:0])
               2'd0: fl = (a == b);
               2'd1: fl = ($signed(a) < $signed(b));
               2'd2: fl = ($signed(a) > $signed(b));
               default: fl = (a < b);
            endcase
            o = {15'd0, fl};
         end
         default: begin
            case (f[1:0])
               2'd0: o = a << b[3:0];
               2'd1: o = a >> b[3:0];
               2'd2: o = $signed(a) >>> b[3:0];
               default: o = {a[14:0], a[15]};
            endcase
            fl = o[15];
         end
      endcase
      return {fl, o};
   endfunction

   // Sub-unit model: registered, disabled units contribute 0, outputs ORed.
   function automatic logic [16:0] unit_eval(input logic [3:0] en, input logic [1:0] uf,
                                             input logic [15:0] a, input logic [15:0] b);
      logic [16:0] acc;
      acc = '0;
      for (int u = 0; u < 4; u++)
         if (en[u]) acc = acc | alu_f({u[1:0], uf}, a, b);
      return acc;
   endfunction

   function automatic logic [3:0] en_now();
      return {bus.SHIFT_Enable, bus.CMP_Enable, bus.Logic_Enable, bus.Arith_Enable};
   endfunction

   logic [16:0] unit_r;
   always @(posedge CLK or negedge RST) begin
      if (!RST) unit_r <= '0;
      else      unit_r <= unit_eval(en_now(), bus.Unit_FUN, bus.Unit_A, bus.Unit_B);
   end
   assign bus.Unit_OUT  = unit_r[15:0];
   assign bus.Unit_Flag = unit_r[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.Req_Valid    = 2'b00;
      bus.Req_A        = '0;
      bus.Req_B        = '0;
      bus.Req_FUN      = '0;
      bus.Result_Ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      exp_cnt = 8'd0;
   endtask

   task automatic wait_accept(input string nm);
      int n;
      bit got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 8) begin
         @(negedge CLK);
         if (|(bus.Req_Valid & bus.Req_Ready)) got = 1'b1;
         else n++;
      end
      chk({nm, "_accept"}, 32'(got), 32'd1);
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [15:0] a0, b0, a1, b1;
      logic [3:0]  f0, f1;
      logic        tag;
      logic [15:0] res;
      logic        flag;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input string nm);
      logic [15:0] a, b;
      logic [3:0]  f;
      a = v.tag ? v.a1 : v.a0;
      b = v.tag ? v.b1 : v.b0;
      f = v.tag ? v.f1 : v.f0;
      @(posedge CLK); #1;
      bus.Req_Valid    = v.valid;
      bus.Req_A        = {v.a1, v.a0};
      bus.Req_B        = {v.b1, v.b0};
      bus.Req_FUN      = {v.f1, v.f0};
      bus.Result_Ready = 1'b0;
      wait_accept(nm);
      chk({nm, "_grant"}, 32'(bus.Req_Ready), v.tag ? 32'd2 : 32'd1);
      @(posedge CLK); #1 bus.Req_Valid = 2'b00;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk({nm, "_en"}, 32'(en_now()), 32'd1 << f[3:2]);
         chk({nm, "_early_valid"}, 32'(bus.Result_Valid), 32'd0);
         chk({nm, "_busy"}, 32'(bus.Busy), 32'd1);
         chk({nm, "_unit_a"}, 32'(bus.Unit_A), 32'(a));
         chk({nm, "_unit_b"}, 32'(bus.Unit_B), 32'(b));
         chk({nm, "_unit_fun"}, 32'(bus.Unit_FUN), 32'(f[1:0]));
      end
      @(negedge CLK);
      chk({nm, "_valid"}, 32'(bus.Result_Valid), 32'd1);
      chk({nm, "_en_off"}, 32'(en_now()), 32'd0);
      chk({nm, "_res"}, 32'(bus.Result), 32'(v.res));
      chk({nm, "_flag"}, 32'(bus.Result_Flag), 32'(v.flag));
      chk({nm, "_tag"}, 32'(bus.Result_Tag), 32'(v.tag));
      bus.Result_Ready = 1'b1;
      @(posedge CLK); #1 bus.Result_Ready = 1'b0;
      exp_cnt++;
      chk({nm, "_count"}, 32'(bus.Op_Count), 32'(exp_cnt));
      chk({nm, "_valid_clr"}, 32'(bus.Result_Valid), 32'd0);
      chk({nm, "_idle"}, 32'(bus.Busy), 32'd0);
   endtask

   // Random run against a transaction-level model: age counts cycles since
   // the accept of the outstanding operation, -1 when nothing is outstanding.
   task automatic random_run(input int cycles);
      int          age;
      logic        m_ptr, g, m_tag, m_flag;
      logic [1:0]  rv, er;
      logic [15:0] m_a, m_b, m_res;
      logic [3:0]  m_f;
      logic [16:0] r;
      age = -1; m_ptr = 1'b0; m_tag = 1'b0; m_flag = 1'b0;
      m_a = '0; m_b = '0; m_res = '0; m_f = '0; g = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge CLK); #1;
         rv = 2'($urandom_range(0, 3));
         bus.Req_Valid    = rv;
         bus.Req_A        = $urandom;
         bus.Req_B        = $urandom;
         bus.Req_FUN      = 8'($urandom);
         bus.Result_Ready = 1'($urandom_range(0, 1));
         @(negedge CLK);
         er = 2'b00;
         if (age < 0 && rv != 2'b00) begin
            if (rv == 2'b01)      g = 1'b0;
            else if (rv == 2'b10) g = 1'b1;
            else                  g = m_ptr;
            er = g ? 2'b10 : 2'b01;
         end
         chk("rnd_ready", 32'(bus.Req_Ready), 32'(er));
         chk("rnd_busy", 32'(bus.Busy), 32'(age >= 0));
         chk("rnd_valid", 32'(bus.Result_Valid), 32'(age >= 2));
         chk("rnd_count", 32'(bus.Op_Count), 32'(exp_cnt));
         chk("rnd_en", 32'(en_now()), (age == 0 || age == 1) ? (32'd1 << m_f[3:2]) : 32'd0);
         if (age >= 0) begin
            chk("rnd_unit_a", 32'(bus.Unit_A), 32'(m_a));
            chk("rnd_unit_b", 32'(bus.Unit_B), 32'(m_b));
            chk("rnd_unit_fun", 32'(bus.Unit_FUN), 32'(m_f[1:0]));
         end
         if (age >= 2) begin
            chk("rnd_res", 32'(bus.Result), 32'(m_res));
            chk("rnd_flag", 32'(bus.Result_Flag), 32'(m_flag));
            chk("rnd_tag", 32'(bus.Result_Tag), 32'(m_tag));
         end
         if (age < 0) begin
            if (er != 2'b00) begin
               m_a   = g ? bus.Req_A[31:16] : bus.Req_A[15:0];
               m_b   = g ? bus.Req_B[31:16] : bus.Req_B[15:0];
               m_f   = g ? bus.Req_FUN[7:4] : bus.Req_FUN[3:0];
               r     = alu_f(m_f, m_a, m_b);
               m_res = r[15:0];
               m_flag = r[16];
               m_tag = g;
               m_ptr = ~g;
               age   = 0;
            end
         end else if (age < 2) begin
            age++;
         end else if (bus.Result_Ready) begin
            age = -1;
            exp_cnt++;
         end
      end
   endtask

   initial begin
      vecs[0] = '{2'b01, 16'd5,      16'd3,      16'd0, 16'd0,      4'b0100, 4'b0000, 1'b0, 16'h0001, 1'b1};
      vecs[1] = '{2'b11, 16'd7,      16'd2,      16'd100, 16'hFFE2, 4'b0000, 4'b0001, 1'b1, 16'h0082, 1'b0};
      vecs[2] = '{2'b11, 16'hFFF8,   16'd3,      16'd9, 16'd9,      4'b1001, 4'b0000, 1'b0, 16'h0001, 1'b1};
      vecs[3] = '{2'b01, 16'h8000,   16'd4,      16'd1, 16'd1,      4'b1110, 4'b0000, 1'b0, 16'hF800, 1'b1};
      vecs[4] = '{2'b10, 16'd1,      16'd1,      16'd3, 16'd5,      4'b0000, 4'b0001, 1'b1, 16'hFFFE, 1'b1};
      vecs[5] = '{2'b11, 16'h00F0,   16'h0F0F,   16'd2, 16'd2,      4'b0110, 4'b0000, 1'b0, 16'h0FFF, 1'b1};
      vecs[6] = '{2'b10, 16'd0,      16'd0,      16'd5, 16'd5,      4'b0000, 4'b1000, 1'b1, 16'h0001, 1'b1};
      vecs[7] = '{2'b11, 16'd1,      16'd4,      16'd7, 16'd7,      4'b1100, 4'b0000, 1'b0, 16'h0010, 1'b0};

      // Reset with random inputs
      idle_inputs();
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         bus.Req_Valid    = 2'($urandom_range(1, 3));
         bus.Req_A        = $urandom;
         bus.Req_B        = $urandom;
         bus.Req_FUN      = 8'($urandom);
         bus.Result_Ready = 1'b1;
         @(negedge CLK);
         chk("rst_ready", 32'(bus.Req_Ready), 32'd0);
         chk("rst_unit", 32'({bus.Unit_A, bus.Unit_B}), 32'd0);
         chk("rst_fun_en", 32'({bus.Unit_FUN, en_now()}), 32'd0);
         chk("rst_result", 32'({bus.Result, bus.Result_Flag, bus.Result_Tag, bus.Result_Valid}), 32'd0);
         chk("rst_busy_cnt", 32'({bus.Busy, bus.Op_Count}), 32'd0);
      end
      do_reset();
      @(negedge CLK);
      chk("post_rst_busy", 32'(bus.Busy), 32'd0);
      chk("post_rst_cnt", 32'(bus.Op_Count), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held in RESP while both requesters wait
      @(posedge CLK); #1;
      bus.Req_Valid = 2'b01;
      bus.Req_A     = {16'd0, 16'h1234};
      bus.Req_B     = {16'd0, 16'h00FF};
      bus.Req_FUN   = 8'h05;
      wait_accept("bp");
      @(posedge CLK); #1 bus.Req_Valid = 2'b11;
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(bus.Result_Valid), 32'd1);
         chk("bp_res", 32'(bus.Result), 32'h12FF);
         chk("bp_flag", 32'(bus.Result_Flag), 32'd1);
         chk("bp_tag", 32'(bus.Result_Tag), 32'd0);
         chk("bp_ready", 32'(bus.Req_Ready), 32'd0);
         chk("bp_count", 32'(bus.Op_Count), 32'(exp_cnt));
         @(negedge CLK);
      end
      bus.Req_Valid    = 2'b00;
      bus.Result_Ready = 1'b1;
      @(posedge CLK); #1 bus.Result_Ready = 1'b0;
      exp_cnt++;
      chk("bp_done_count", 32'(bus.Op_Count), 32'(exp_cnt));
      chk("bp_done_valid", 32'(bus.Result_Valid), 32'd0);

      // Reset during CAPTURE aborts the operation
      @(posedge CLK); #1;
      bus.Req_Valid = 2'b01;
      bus.Req_FUN   = 8'h00;
      wait_accept("mid");
      @(posedge CLK); #1 bus.Req_Valid = 2'b00;
      @(posedge CLK); #1;
      chk("mid_capture_en", 32'(en_now()), 32'd1);
      RST = 1'b0;
      #1;
      chk("mid_en", 32'(en_now()), 32'd0);
      chk("mid_valid", 32'(bus.Result_Valid), 32'd0);
      chk("mid_busy", 32'(bus.Busy), 32'd0);
      chk("mid_count", 32'(bus.Op_Count), 32'd0);
      exp_cnt = 8'd0;
      bus.Result_Ready = 1'b1;
      @(posedge CLK); #1 RST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("mid_no_result", 32'({bus.Result_Valid, bus.Busy}), 32'd0);
      end
      bus.Result_Ready = 1'b0;

      random_run(3000);

      // Contention: both requesters always valid, consumer always ready
      do_reset();
      bus.Req_Valid    = 2'b11;
      bus.Req_A        = {16'd10, 16'd20};
      bus.Req_B        = {16'd1, 16'd2};
      bus.Req_FUN      = 8'h00;
      bus.Result_Ready = 1'b1;
      for (int op = 0; op < 6; op++) begin
         @(negedge CLK);
         chk("cont_grant", 32'(bus.Req_Ready), (op % 2 == 1) ? 32'd2 : 32'd1);
         repeat (2) begin
            @(negedge CLK);
            chk("cont_ready_low", 32'(bus.Req_Ready), 32'd0);
         end
         @(negedge CLK);
         chk("cont_ready_resp", 32'(bus.Req_Ready), 32'd0);
         chk("cont_tag", 32'({bus.Result_Valid, bus.Result_Tag}), {30'd0, 1'b1, 1'(op % 2)});
      end
      @(negedge CLK);
      chk("cont_count", 32'(bus.Op_Count), 32'd6);
      idle_inputs();

      // Wrap: 256 completions return Op_Count to 0
      do_reset();
      bus.Req_Valid    = 2'b01;
      bus.Result_Ready = 1'b1;
      for (int i = 0; i <= 1024; i++) begin
         @(negedge CLK);
         if (i == 1020) chk("wrap_255", 32'(bus.Op_Count), 32'd255);
         if (i == 1024) begin
            chk("wrap_0", 32'(bus.Op_Count), 32'd0);
            chk("wrap_idle", 32'(bus.Busy), 32'd0);
         end
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
Two-requester round-robin scheduler that shares one structural signed ALU (arithmetic, logic, compare and shift sub-units) between two clients. It accepts one operation at a time over a valid/ready handshake and decodes the 4-bit function into a one-hot sub-unit enable plus a 2-bit sub-function. It waits for the registered sub-unit result, captures it, and returns it with a requester tag. It sits between the client masters and the ALU sub-units.

Parameters:
IN_WIDTH, 16, operand width (A/B, signed)
OUT_WIDTH, 16, sub-unit result width
CNT_WIDTH, 8, completed-operation counter width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
Req_Valid  input  2  per-requester request valid; bit i = requester i
Req_Ready  output  2  per-requester accept; at most one bit high per cycle
Req_A  input  2*IN_WIDTH  operand A; slice [i*IN_WIDTH +: IN_WIDTH] belongs to requester i
Req_B  input  2*IN_WIDTH  operand B; same slicing as Req_A
Req_FUN  input  8  function; [i*4 +: 4] belongs to requester i
Unit_A  output  IN_WIDTH  operand A driven to the sub-units
Unit_B  output  IN_WIDTH  operand B driven to the sub-units
Unit_FUN  output  2  sub-function to the sub-units
Arith_Enable  output  1  arithmetic unit enable
Logic_Enable  output  1  logic unit enable
CMP_Enable  output  1  compare unit enable
SHIFT_Enable  output  1  shift unit enable
Unit_OUT  input  OUT_WIDTH  OR of all sub-unit outputs (a disabled unit drives 0)
Unit_Flag  input  1  OR of all sub-unit flags
Result  output  OUT_WIDTH  captured result
Result_Flag  output  1  captured flag
Result_Tag  output  1  index of the requester that owns Result
Result_Valid  output  1  result available
Result_Ready  input  1  consumer accepts the result
Busy  output  1  high in every state except IDLE
Op_Count  output  CNT_WIDTH  count of completed operations; wraps

Behaviour:
- Reset (async, RST=0): state IDLE. All outputs 0: Req_Ready, Unit_A/B/FUN, all enables, Result, Result_Flag, Result_Tag, Result_Valid, Busy, Op_Count. Round-robin pointer = 0 (requester 0 has priority). Reset mid-operation aborts the operation; no result is delivered.
- IDLE: if any Req_Valid bit is set, grant one requester. If both are set, grant the one the pointer selects. If one is set, grant it regardless of the pointer.
- Req_Ready[g] is combinational: high only in IDLE and only for the granted g. An accept occurs on the edge where Req_Valid[g] & Req_Ready[g]. On that edge: latch A/B/FUN from slice g, set Tag=g, set pointer = ~g, go to ISSUE.
- Decode of FUN[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift. Unit_FUN = FUN[1:0].
- ISSUE (1 cycle): exactly one enable high; Unit_A, Unit_B and Unit_FUN driven from the latched values. The sub-unit registers its result at the end of this cycle. Go to CAPTURE.
- CAPTURE (1 cycle): the same enable stays high and the operands are held. On the closing edge: Result <= Unit_OUT, Result_Flag <= Unit_Flag, Result_Valid <= 1, enables <= 0, go to RESP.
- RESP: hold Result, Result_Flag, Result_Tag and Result_Valid stable until Result_Valid & Result_Ready. On that edge: Result_Valid <= 0, Op_Count += 1 (wraps from 2^CNT_WIDTH-1 to 0), go to IDLE.
- Latency: accept at edge k gives Result_Valid high from edge k+2. Minimum issue interval is 4 cycles (IDLE-ISSUE-CAPTURE-RESP) when Result_Ready is held high.
- Enables are low in IDLE and RESP. Unit_A, Unit_B and Unit_FUN hold their last values outside ISSUE/CAPTURE.
- A requester that drops Req_Valid before acceptance is not served. A pending request from the other requester is granted on the next IDLE cycle.
- Requests are never accepted while Busy is high. Req_Ready is 0 in every state except IDLE.

Test Plan:
- Reset: hold RST=0 with random inputs -> all outputs 0; after release Busy=0 and Op_Count=0.
- Single op: requester 0 sends A=5, B=3, FUN=4'b0100 (logic AND) -> Logic_Enable is the only enable high for exactly 2 cycles; with a logic unit model, Result=1, Result_Flag=1, Tag=0, Result_Valid 2 edges after accept.
- Contention: both valid each cycle, Result_Ready=1, ops issued 6 times -> grants alternate 0,1,0,1,0,1; Op_Count=6; each op completes in 4 cycles.
- Backpressure: Result_Ready=0 for 10 cycles in RESP -> Result, Result_Flag and Tag are stable, Req_Ready stays 0, Op_Count does not change; raise Result_Ready -> one completion counted.
- Reset mid-op: assert RST=0 during CAPTURE -> enables, Result_Valid and Busy drop immediately; no result is delivered after release.
- Wrap: 256 completions -> Op_Count returns to 0.
